frame_buffer_db: RTL and testbench
==================================

# frame_buffer_db

Parametrised double-buffered frame buffer between the ray-casting/transformation stage and the TMDS encoders. The ray side writes a low-resolution frame into the back buffer while the video side reads the front buffer, upscaled by an integer factor and expanded to 24-bit RGB. The buffers swap at the video frame boundary only after the ray side has completed a frame, so the screen never shows a partially drawn frame.

## Interface
Parameters:
- FB_WIDTH, 320: stored frame width in pixels
- FB_HEIGHT, 180: stored frame height in pixels
- SCALE, 4: integer upscale factor per axis; must be a power of two
- COLOR_MODE, 0: 0 = RGB565 (16-bit stored pixel), 1 = RGB332 (8-bit stored pixel)
- BORDER_COLOR, 24'h000000: output colour outside the FB_WIDTH·SCALE × FB_HEIGHT·SCALE region
- Derived: ADDR_WIDTH = $clog2(FB_WIDTH·FB_HEIGHT); PIXEL_WIDTH = 16 (mode 0) or 8 (mode 1)

Ports:
- pixel_clk_in  in  1  pixel clock; the only clock
- rst_in  in  1  reset, asynchronous assert, active-low
- hcount_in  in  11  video horizontal count
- vcount_in  in  10  video vertical count
- video_last_pixel_in  in  1  one-cycle pulse on the final pixel of the video frame
- addr_in  in  ADDR_WIDTH  write address, row-major (y·FB_WIDTH + x)
- pixel_in  in  PIXEL_WIDTH  write data
- valid_in  in  1  write request
- ready_out  out  1  write accepted when valid_in && ready_out
- ray_last_pixel_in  in  1  pulse marking the end of the ray frame; may coincide with the last valid_in
- rgb_out  out  24  {R8,G8,B8} for the pixel at (hcount_in, vcount_in) three cycles earlier
- swap_out  out  1  one-cycle pulse when front and back swap
- stale_frames_out  out  8  saturating count of video frames that ended without a swap

## Operation
- Two buffer banks, FB_WIDTH·FB_HEIGHT × PIXEL_WIDTH each, simple dual-port BRAM, 2-cycle read latency. The front_sel bit selects the read bank; the write bank is !front_sel.
- Write FSM:
  - WRITING (ready_out=1): an accepted write stores pixel_in at addr_in in the back bank. On ray_last_pixel_in, including the same-cycle last write: if video_last_pixel_in is also high, swap this cycle and stay in WRITING; otherwise go to WAIT_SWAP.
  - WAIT_SWAP (ready_out=0): writes are not performed and ray_last_pixel_in is ignored. On video_last_pixel_in: toggle front_sel, pulse swap_out, go to WRITING.
- video_last_pixel_in in WRITING without ray_last_pixel_in: no swap. stale_frames_out increments and saturates at 255.
- addr_in ≥ FB_WIDTH·FB_HEIGHT: the write is accepted and discarded.
- Read address = (vcount_in/SCALE)·FB_WIDTH + hcount_in/SCALE, computed with shifts and one constant multiply.
- Out of region when hcount_in ≥ FB_WIDTH·SCALE or vcount_in ≥ FB_HEIGHT·SCALE. The out-of-region flag and front_sel travel down the pipeline with the address.
- Colour expansion uses MSB replication:
  - Mode 0: R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}.
  - Mode 1: R={r3,r3,r3[2:1]}, G={g3,g3,g3[2:1]}, B={b2,b2,b2,b2}.

## Timing
- Reset (rst_in=0, asynchronous): FSM=WRITING, front_sel=0, ready_out=1, rgb_out=0, swap_out=0, stale_frames_out=0. BRAM contents are not cleared.
- Read pipeline:
  - Cycle 0: register address and flags.
  - Cycles 1–2: BRAM read.
  - rgb_out is registered, 3 cycles after hcount_in/vcount_in.
- Writes take effect the cycle after acceptance. A read of the same address in the same bank is not required to be coherent, because the front bank is never written.
- front_sel changes on the clock edge after video_last_pixel_in. The first pixel of the next frame reads the new front bank.
- swap_out is high for exactly the cycle following the swap decision.
- ready_out falls the cycle after ray_last_pixel_in and rises the cycle after the swap.
- Reset mid-WAIT_SWAP returns to WRITING with front_sel=0. The pending frame is lost.

## Test plan
- Reset: hold rst_in=0 mid-frame → ready_out=1, rgb_out=0, swap_out=0, stale_frames_out=0, all forced asynchronously before the next edge.
- Write-and-display, mode 0:
  - Stimulus: write 16'hF800 to addr 0 and 16'h07E0 to addr 1, pulse ray_last, then pulse video_last.
  - Response: swap_out pulses once. Next frame, hcount 0–3 / vcount 0–3 give rgb_out 24'hFF0000 and hcount 4–7 give 24'h00FF00, each 3 cycles late.
- Backpressure:
  - Stimulus: after ray_last, hold valid_in=1 with pixel 16'h001F at addr 0 until video_last.
  - Response: ready_out=0 throughout, the write is not stored, and the displayed addr 0 colour is unchanged.
- Simultaneous events:
  - Stimulus: ray_last and video_last in the same cycle while in WRITING.
  - Response: immediate swap, swap_out pulses, ready_out stays 1.
- Stale frames: 300 video_last pulses with no ray_last → no swap, stale_frames_out saturates at 255, displayed image unchanged.
- Border and mode 1:
  - Stimulus: COLOR_MODE=1, write 8'hE0, swap, then read hcount=1280.
  - Response: rgb_out=BORDER_COLOR. The in-region pixel shows 24'hFF0000.

Source files
------------

// File: rtl/frame_buffer_db.sv
// frame_buffer_db: double-buffered low-res frame store, upscaled and colour-expanded for video out
module frame_buffer_db #(
    parameter int          FB_WIDTH     = 320,
    parameter int          FB_HEIGHT    = 180,
    parameter int          SCALE        = 4,
    parameter int          COLOR_MODE   = 0,
    parameter logic [23:0] BORDER_COLOR = 24'h000000,
    parameter int          ADDR_WIDTH   = $clog2(FB_WIDTH * FB_HEIGHT),
    parameter int          PIXEL_WIDTH  = (COLOR_MODE == 0) ? 16 : 8
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   video_last_pixel_in,
    input  logic [ADDR_WIDTH-1:0]  addr_in,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic                   ray_last_pixel_in,
    output logic [23:0]            rgb_out,
    output logic                   swap_out,
    output logic [7:0]             stale_frames_out
);
    localparam int DEPTH = FB_WIDTH * FB_HEIGHT;
    localparam int SHIFT = $clog2(SCALE);

    typedef enum logic {WRITING, WAIT_SWAP} state_t;

    state_t                  state_q, state_d;
    logic                    front_sel_q, front_sel_d;
    logic                    swap_q, swap_d;
    logic [7:0]              stale_q, stale_d;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    oob0_q, oob0_d, oob1_q, sel0_q, sel1_q;
    logic [PIXEL_WIDTH-1:0]  rd0_q, rd1_q;
    logic [15:0]             px;
    logic [23:0]             rgb_q, rgb_d;
    logic [PIXEL_WIDTH-1:0]  mem0 [DEPTH];
    logic [PIXEL_WIDTH-1:0]  mem1 [DEPTH];

    // write FSM: accept writes into the back bank, swap banks only at a video frame boundary
    always_comb begin
        state_d = state_q;
        swap_d  = 1'b0;
        stale_d = stale_q;
        wr_en   = 1'b0;
        if (state_q == WRITING) begin
            wr_en = valid_in && (32'(addr_in) < 32'(DEPTH));
            if (ray_last_pixel_in) begin
                swap_d  = video_last_pixel_in;
                state_d = video_last_pixel_in ? WRITING : WAIT_SWAP;
            end else if (video_last_pixel_in && stale_q != 8'hFF) begin
                stale_d = stale_q + 8'd1;
            end
        end else begin
            swap_d  = video_last_pixel_in;
            state_d = video_last_pixel_in ? WRITING : WAIT_SWAP;
        end
        front_sel_d = front_sel_q ^ swap_d;
    end

    // read address from the upscaled raster position; out-of-region reads park at address 0
    always_comb begin
        oob0_d    = (32'(hcount_in) >= 32'(FB_WIDTH * SCALE)) || (32'(vcount_in) >= 32'(FB_HEIGHT * SCALE));
        rd_addr_d = oob0_d ? '0 : ADDR_WIDTH'((32'(vcount_in) >> SHIFT) * 32'(FB_WIDTH) + (32'(hcount_in) >> SHIFT));
    end

    // MSB-replicating colour expansion of the fetched front-bank pixel, or the border colour
    always_comb begin
        px    = 16'(sel1_q ? rd1_q : rd0_q);
        rgb_d = oob1_q ? BORDER_COLOR : (COLOR_MODE == 0)
            ? {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]}
            : {px[7:5], px[7:5], px[7:6], px[4:2], px[4:2], px[4:3], {4{px[1:0]}}};
    end

    // FSM, bank select and read pipeline registers
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= WRITING;
            front_sel_q <= 1'b0;
            swap_q      <= 1'b0;
            stale_q     <= 8'd0;
            rd_addr_q   <= '0;
            oob0_q      <= 1'b0;
            oob1_q      <= 1'b0;
            sel0_q      <= 1'b0;
            sel1_q      <= 1'b0;
            rgb_q       <= 24'd0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            swap_q      <= swap_d;
            stale_q     <= stale_d;
            rd_addr_q   <= rd_addr_d;
            oob0_q      <= oob0_d;
            oob1_q      <= oob0_q;
            sel0_q      <= front_sel_q;
            sel1_q      <= sel0_q;
            rgb_q       <= rgb_d;
        end
    end

    // two simple dual-port banks; contents survive reset
    always_ff @(posedge pixel_clk_in) begin
        if (wr_en && front_sel_q)
            mem0[addr_in] <= pixel_in;
        if (wr_en && !front_sel_q)
            mem1[addr_in] <= pixel_in;
        rd0_q <= mem0[rd_addr_q];
        rd1_q <= mem1[rd_addr_q];
    end

    assign ready_out        = (state_q == WRITING);
    assign rgb_out          = rgb_q;
    assign swap_out         = swap_q;
    assign stale_frames_out = stale_q;
endmodule

// File: tb/tb_frame_buffer_db.sv
// tb_frame_buffer_db: randomized and directed checks of frame_buffer_db against a frame-level model
module tb_frame_buffer_db;
    localparam int W = 320;
    localparam int H = 180;
    localparam int S = 4;
    localparam int DEPTH = W * H;
    localparam logic [23:0] BORDER1 = 24'h0A0B0C;

    typedef struct {
        bit          chk;
        logic [23:0] e0;
        logic [23:0] e1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] h = '0;
    logic [9:0]  v = '0;
    logic [15:0] addr = '0;
    logic [15:0] pix = '0;
    logic        valid = 1'b0;
    logic        rl = 1'b0;
    logic        vl = 1'b0;
    logic        ready0, ready1, swap0, swap1;
    logic [23:0] rgb0, rgb1;
    logic [7:0]  stale0, stale1;

    logic [15:0] bank [2][DEPTH];
    bit          known [2][DEPTH];
    bit          pending = 0;
    bit          front = 0;
    bit          swap_e = 0;
    int          stale = 0;
    int          idx = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];

    always #5 clk = ~clk;

    frame_buffer_db u_dut0 (
        .pixel_clk_in(clk), .rst_in(rst_n), .hcount_in(h), .vcount_in(v),
        .video_last_pixel_in(vl), .addr_in(addr), .pixel_in(pix), .valid_in(valid),
        .ready_out(ready0), .ray_last_pixel_in(rl), .rgb_out(rgb0), .swap_out(swap0),
        .stale_frames_out(stale0)
    );

    frame_buffer_db #(.COLOR_MODE(1), .BORDER_COLOR(BORDER1)) u_dut1 (
        .pixel_clk_in(clk), .rst_in(rst_n), .hcount_in(h), .vcount_in(v),
        .video_last_pixel_in(vl), .addr_in(addr), .pixel_in(pix[7:0]), .valid_in(valid),
        .ready_out(ready1), .ray_last_pixel_in(rl), .rgb_out(rgb1), .swap_out(swap1),
        .stale_frames_out(stale1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp0(input logic [15:0] p);
        int r = int'(p[15:11]);
        int g = int'(p[10:5]);
        int b = int'(p[4:0]);
        return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
    endfunction

    function automatic logic [23:0] exp1(input logic [7:0] p);
        int r = int'(p[7:5]);
        int g = int'(p[4:2]);
        int b = int'(p[1:0]);
        return {8'((r << 5) | (r << 2) | (r >> 1)), 8'((g << 5) | (g << 2) | (g >> 1)), 8'(b * 85)};
    endfunction

    // one clock: predict this edge, advance, then compare every output
    task automatic cycle();
        exp_t e;
        int a;
        e.chk = 1;
        e.e0 = 24'd0;
        e.e1 = BORDER1;
        if (!(int'(h) >= W * S || int'(v) >= H * S)) begin
            a = (int'(v) / S) * W + int'(h) / S;
            e.chk = known[front][a];
            e.e0 = exp0(bank[front][a]);
            e.e1 = exp1(bank[front][a][7:0]);
        end
        q.push_back(e);
        swap_e = 0;
        if (!pending) begin
            if (valid && int'(addr) < DEPTH) begin
                bank[!front][addr] = pix;
                known[!front][addr] = 1;
            end
            if (rl) begin
                if (vl) swap_e = 1;
                else pending = 1;
            end else if (vl && stale < 255) begin
                stale++;
            end
        end else if (vl) begin
            swap_e = 1;
            pending = 0;
        end
        if (swap_e) front = !front;
        @(posedge clk);
        #1;
        check("ready0", ready0, !pending);
        check("ready1", ready1, !pending);
        check("swap0", swap0, swap_e);
        check("swap1", swap1, swap_e);
        check("stale0", stale0, stale);
        check("stale1", stale1, stale);
        e = q.pop_front();
        if (e.chk) begin
            check("rgb0", rgb0, e.e0);
            check("rgb1", rgb1, e.e1);
        end
    endtask

    task automatic scan();
        h = 11'(idx % 36);
        v = 10'((idx / 36) % 16);
        idx++;
    endtask

    task automatic idle();
        valid = 0;
        rl = 0;
        vl = 0;
    endtask

    task automatic do_reset();
        exp_t n;
        n = '{chk: 0, e0: 24'd0, e1: 24'd0};
        idle();
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check("rst_ready0", ready0, 1);
        check("rst_ready1", ready1, 1);
        check("rst_rgb0", rgb0, 0);
        check("rst_rgb1", rgb1, 0);
        check("rst_swap0", swap0, 0);
        check("rst_stale0", stale0, 0);
        check("rst_stale1", stale1, 0);
        pending = 0;
        front = 0;
        stale = 0;
        q.delete();
        q.push_back(n);
        q.push_back(n);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1;
    endtask

    task automatic read_px(input int hh, input int vv, input logic [23:0] e0, input logic [23:0] e1);
        idle();
        h = 11'(hh);
        v = 10'(vv);
        repeat (3) cycle();
        check("px_mode0", rgb0, e0);
        check("px_mode1", rgb1, e1);
    endtask

    task automatic fill(input logic [15:0] p0, input logic [15:0] p1, input bit last_rl);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                addr = 16'(y * W + x);
                pix = (addr == 0) ? p0 : (addr == 1) ? p1 : 16'($urandom);
                valid = 1;
                rl = last_rl && y == 3 && x == 7;
                scan();
                cycle();
            end
        end
        idle();
    endtask

    initial begin
        do_reset();
        // write-and-display
        fill(16'hF800, 16'h07E0, 0);
        rl = 1;
        scan();
        cycle();
        rl = 0;
        check("ray_ready_low", ready0, 0);
        repeat (4) begin scan(); cycle(); end
        vl = 1;
        scan();
        cycle();
        vl = 0;
        check("swap_pulse", swap0, 1);
        cycle();
        check("swap_once", swap0, 0);
        check("ready_back", ready0, 1);
        read_px(0, 0, 24'hFF0000, 24'h000000);
        read_px(3, 3, 24'hFF0000, 24'h000000);
        read_px(4, 0, 24'h00FF00, 24'hFF0000);
        read_px(7, 3, 24'h00FF00, 24'hFF0000);
        read_px(1280, 0, 24'h000000, BORDER1);
        read_px(0, 720, 24'h000000, BORDER1);
        // backpressure: writes held during WAIT_SWAP are dropped
        fill(16'hFFE0, 16'($urandom), 1);
        valid = 1;
        addr = 16'd0;
        pix = 16'h001F;
        repeat (5) begin scan(); cycle(); check("bp_ready", ready0, 0); end
        vl = 1;
        scan();
        cycle();
        idle();
        check("bp_swap", swap0, 1);
        read_px(0, 0, 24'hFFFF00, 24'hFF0000);
        // simultaneous ray_last and video_last with a final write
        valid = 1;
        addr = 16'd1;
        pix = 16'h001F;
        rl = 1;
        vl = 1;
        scan();
        cycle();
        idle();
        check("sim_swap", swap0, 1);
        check("sim_ready", ready0, 1);
        read_px(4, 0, 24'h0000FF, 24'h00FFFF);
        // stale frames saturate
        repeat (300) begin
            vl = 1; scan(); cycle();
            vl = 0; scan(); cycle();
        end
        check("stale_sat", stale0, 255);
        read_px(4, 0, 24'h0000FF, 24'h00FFFF);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r = int'($urandom % 10);
            valid = 1'($urandom);
            addr = ($urandom % 8 == 0) ? 16'(DEPTH + int'($urandom % 7936)) : 16'(int'($urandom % 4) * W + int'($urandom % 8));
            pix = 16'($urandom);
            rl = ($urandom % 40 == 0);
            vl = ($urandom % 30 == 0);
            h = (r == 0) ? 11'(1270 + $urandom % 20) : 11'($urandom % 32);
            v = (r == 1) ? 10'(710 + $urandom % 20) : 10'($urandom % 16);
            cycle();
        end
        idle();
        // reset while waiting for a swap drops the pending frame
        if (pending) begin
            vl = 1;
            cycle();
            vl = 0;
        end
        rl = 1;
        cycle();
        rl = 0;
        check("pend_ready", ready0, 0);
        do_reset();
        repeat (4) begin scan(); cycle(); end
        read_px(0, 0, exp0(bank[0][0]), exp1(bank[0][0][7:0]));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
